// File: rtl/mode_select.sv
// Debounced board-switch mode selector: synchronises and debounces the switch
// code, then applies a valid new mode only at the start of a video frame.
module mode_select #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int MAX_MODE        = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] chaves,
    input  logic       vsync,
    output logic [2:0] modo,
    output logic       mudou,
    output logic       erro
);

    localparam int             CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]     MAX_CODE = 3'(MAX_MODE);

    typedef enum logic [1:0] {
        ESTAVEL  = 2'd0,
        PENDENTE = 2'd1,
        APLICA   = 2'd2
    } state_t;

    logic [2:0]       sync_d;
    logic [2:0]       sync_q;
    logic [2:0]       candidate;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       estavel;
    logic             vsync_reg;
    logic             vs_fall;
    state_t           state_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_d <= '0;
            sync_q <= '0;
        end else begin
            sync_d <= chaves;
            sync_q <= sync_d;
        end
    end

    // Any change of the synchronised value restarts the stability count;
    // once saturated, the counter parks and estavel simply tracks candidate.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            candidate <= '0;
            cnt       <= '0;
            estavel   <= '0;
        end else if (sync_q != candidate) begin
            candidate <= sync_q;
            cnt       <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end else begin
            estavel <= candidate;
        end
    end

    assign erro = (estavel > MAX_CODE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vsync_reg <= 1'b1;
        end else begin
            vsync_reg <= vsync;
        end
    end

    assign vs_fall = vsync_reg & ~vsync;

    // modo and mudou are loaded on the edge entering APLICA, so both show
    // their new values during the APLICA cycle itself.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ESTAVEL;
            modo      <= '0;
            mudou     <= 1'b0;
        end else begin
            case (state_reg)
                ESTAVEL: begin
                    mudou <= 1'b0;
                    if (estavel != modo && !erro) begin
                        state_reg <= PENDENTE;
                    end
                end
                PENDENTE: begin
                    if (estavel == modo || erro) begin
                        state_reg <= ESTAVEL;
                    end else if (vs_fall) begin
                        state_reg <= APLICA;
                        modo      <= estavel;
                        mudou     <= 1'b1;
                    end
                end
                APLICA: begin
                    mudou     <= 1'b0;
                    state_reg <= ESTAVEL;
                end
                default: begin
                    mudou     <= 1'b0;
                    state_reg <= ESTAVEL;
                end
            endcase
        end
    end

endmodule

// File: doc/mode_select.md
MODE_SELECT -- requirements
Module: mode_select

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000, the number of consecutive stable clock cycles (10 ms at 25 MHz) before a switch value is accepted.
REQ-002 SHALL have parameter MAX_MODE, default 4, the highest valid mode code; codes above it are invalid.
REQ-003 SHALL have port clock, input, 1, the single 25 MHz pixel clock (clock_25mhz domain).
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port chaves, input, 3, raw board switch levels, asynchronous to clock.
REQ-006 SHALL have port vsync, input, 1, active-low vertical sync from the VGA controller.
REQ-007 SHALL have port modo, output, 3, the registered mode code driven to the cpu ch input.
REQ-008 SHALL have port mudou, output, 1, a one-cycle pulse in the cycle modo takes a new value.
REQ-009 SHALL have port erro, output, 1, a level that is high while the debounced switch value is invalid.

Function
REQ-010 SHALL pass chaves through a 2-flop synchronizer; sync_q is the second flop.
REQ-011 SHALL hold candidate[2:0] and cnt; when sync_q != candidate, candidate <= sync_q and cnt <= 0 in the same cycle.
REQ-012 SHALL increment cnt while sync_q == candidate and cnt < DEBOUNCE_CYCLES-1.
REQ-013 SHALL load estavel <= candidate in the cycle cnt == DEBOUNCE_CYCLES-1 and sync_q == candidate, then hold cnt saturated there.
REQ-014 SHALL set erro = 1 combinationally from estavel > MAX_MODE; an invalid estavel never reaches modo.
REQ-015 SHALL detect the start of a frame as vsync sampled 1 in the previous cycle and 0 in the current cycle (vs_fall), using a registered copy of vsync.
REQ-016 SHALL implement an FSM with states ESTAVEL, PENDENTE and APLICA.
REQ-017 In ESTAVEL, the FSM SHALL go to PENDENTE when estavel != modo and estavel <= MAX_MODE; otherwise it SHALL stay.
REQ-018 In PENDENTE, the FSM SHALL return to ESTAVEL without a change if estavel == modo or estavel becomes invalid.
REQ-019 In PENDENTE, the FSM SHALL otherwise go to APLICA on vs_fall, with the return check taking priority over vs_fall in the same cycle.
REQ-020 In APLICA, the block SHALL set modo <= estavel and mudou = 1 for exactly that cycle, then go to ESTAVEL unconditionally.
REQ-021 SHALL change modo only in APLICA, so a mode never switches mid-frame.
REQ-022 SHALL, when estavel changes again while PENDENTE, apply the latest valid estavel at the next vs_fall; at most one mudou pulse per frame.
REQ-023 SHALL make the latency from a stable chaves edge to modo equal to 2 sync cycles + DEBOUNCE_CYCLES + the wait to the next vs_fall + 1 cycle.
REQ-024 SHALL, if vsync is held low or held high indefinitely, never produce vs_fall; modo then holds.
REQ-025 SHALL size cnt to ceil(log2(DEBOUNCE_CYCLES)) bits, with no wrap-around.

Reset
REQ-026 SHALL, while reset = 0, asynchronously clear the synchronizer flops, candidate, cnt, estavel, modo and mudou to 0, set the vsync register to 1 and put the FSM in ESTAVEL.
REQ-027 SHALL abandon any pending change on a reset mid-operation; after release the block restarts debouncing from 0.
REQ-028 SHALL report erro = 0 out of reset, since estavel = 0.

Verification (DEBOUNCE_CYCLES = 8 for simulation)
REQ-029 Reset then chaves = 3 held: modo = 0 until the first vs_fall after 2+8 cycles; modo = 3 one cycle later; mudou high 1 cycle.
REQ-030 chaves toggles 2 -> 0 -> 2 every 4 cycles for 40 cycles, then stays 0: no estavel update during toggling; final modo = 0; no mudou while bouncing.
REQ-031 chaves = 6 stable: erro = 1 after debounce; modo unchanged; no mudou across 3 frames.
REQ-032 estavel = 1, then 4 before any vs_fall, then vs_fall: a single mudou; modo = 4.
REQ-033 estavel = 2 pending, then reset = 0 for 3 cycles and released, chaves still 2, then vs_fall before the 10-cycle debounce completes: modo stays 0 that frame and becomes 2 at the following vs_fall.
REQ-034 estavel returns to the current modo while PENDENTE in the same cycle as vs_fall: FSM returns to ESTAVEL; mudou = 0.
